// File: rtl/fft_stage_sequencer.sv
// Iterative FFT controller: holds one frame in a register bank and runs it through a
// shared stage datapath LOG2N times. Optional per-stage >>>1 scaling: FFT_SEQ_STAGE_SCALE_EN.
module fft_stage_sequencer #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  parameter int LOG2N      = $clog2(N_SAMPLES),
  localparam int SW        = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_real,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_imag,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag,
  output logic                                send_val,
  input  logic                                send_rdy,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] stage_send_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] stage_send_imag,
  output logic                                stage_send_val,
  input  logic                                stage_send_rdy,
  output logic [SW-1:0]                       stage_idx,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] stage_recv_real,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] stage_recv_imag,
  input  logic                                stage_recv_val,
  output logic                                stage_recv_rdy,
  output logic                                busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [SW-1:0] LAST = SW'(LOG2N - 1);

  // DECIMAL_PT only constrains scaling semantics; reject nonsensical settings early.
  if (DECIMAL_PT < 0 || DECIMAL_PT >= BIT_WIDTH) begin : g_bad_pt
    $error("DECIMAL_PT must lie in [0, BIT_WIDTH)");
  end
  if (N_SAMPLES < 4 || (1 << LOG2N) != N_SAMPLES) begin : g_bad_n
    $error("N_SAMPLES must be a power of two >= 4");
  end

  logic [1:0]                          state;
  logic [SW-1:0]                       cnt;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] bank_real, bank_imag;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] wr_real, wr_imag;

  logic recv_fire, issue_fire, result_fire, send_fire;

  assign recv_rdy       = (state == IDLE);
  assign stage_send_val = (state == ISSUE);
  assign stage_recv_rdy = (state == WAIT);
  assign send_val       = (state == DONE);
  assign busy           = (state != IDLE);
  assign stage_idx      = (state == IDLE) ? '0 : cnt;

  assign recv_fire   = recv_val && recv_rdy;
  assign issue_fire  = stage_send_val && stage_send_rdy;
  assign result_fire = stage_recv_val && stage_recv_rdy;
  assign send_fire   = send_val && send_rdy;

  assign stage_send_real = bank_real;
  assign stage_send_imag = bank_imag;
  assign send_msg_real   = bank_real;
  assign send_msg_imag   = bank_imag;

  always_comb begin
    wr_real = stage_recv_real;
    wr_imag = stage_recv_imag;
`ifdef FFT_SEQ_STAGE_SCALE_EN
    // Halving every stage gives an overall 1/N scale, so the frame never grows.
    for (int i = 0; i < N_SAMPLES; i++) begin
      wr_real[i] = BIT_WIDTH'($signed(stage_recv_real[i]) >>> 1);
      wr_imag[i] = BIT_WIDTH'($signed(stage_recv_imag[i]) >>> 1);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bank_real <= '0;
      bank_imag <= '0;
    end else begin
      case (state)
        IDLE: if (recv_fire) begin
          bank_real <= recv_msg_real;
          bank_imag <= recv_msg_imag;
          cnt       <= '0;
          state     <= ISSUE;
        end
        ISSUE: if (issue_fire) state <= WAIT;
        WAIT: if (result_fire) begin
          bank_real <= wr_real;
          bank_imag <= wr_imag;
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= ISSUE;
          end
        end
        DONE: if (send_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer (N=8). Stage responder is either identity or
// twiddle-free radix-2 butterflies (exact for impulse/DC frames); it answers in the 2nd WAIT cycle.
module tb_fft_stage_sequencer;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int LG = 3;
`ifdef FFT_SEQ_STAGE_SCALE_EN
  localparam int SH = LG;
`else
  localparam int SH = 0;
`endif

  typedef logic [N-1:0][W-1:0] frame_t;
  typedef struct {
    frame_t in_re;
    frame_t in_im;
    logic   mode;
    frame_t exp_re;
    frame_t exp_im;
  } vec_t;

  logic clk = 0, reset = 1;
  frame_t recv_msg_real = '0, recv_msg_imag = '0;
  logic recv_val = 0, recv_rdy;
  frame_t send_msg_real, send_msg_imag;
  logic send_val, send_rdy = 1;
  frame_t stage_send_real, stage_send_imag;
  logic stage_send_val, stage_send_rdy = 1;
  logic [1:0] stage_idx;
  frame_t stage_recv_real = '0, stage_recv_imag = '0;
  logic stage_recv_val, stage_recv_rdy, busy;

  int nvec = 0, nerr = 0;
  logic mode = 0, stray = 0, p1 = 0, p2 = 0;
  int idx_log[$];
  vec_t tbl[4];

  always #5 clk = ~clk;

  fft_stage_sequencer #(.BIT_WIDTH(W), .DECIMAL_PT(16), .N_SAMPLES(N)) dut (
    .clk(clk), .reset(reset),
    .recv_msg_real(recv_msg_real), .recv_msg_imag(recv_msg_imag),
    .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg_real(send_msg_real), .send_msg_imag(send_msg_imag),
    .send_val(send_val), .send_rdy(send_rdy),
    .stage_send_real(stage_send_real), .stage_send_imag(stage_send_imag),
    .stage_send_val(stage_send_val), .stage_send_rdy(stage_send_rdy),
    .stage_idx(stage_idx),
    .stage_recv_real(stage_recv_real), .stage_recv_imag(stage_recv_imag),
    .stage_recv_val(stage_recv_val), .stage_recv_rdy(stage_recv_rdy),
    .busy(busy)
  );

  function automatic frame_t stage_fn(input logic m, input int idx, input frame_t x);
    frame_t y;
    int span;
    y = x;
    if (m) begin
      span = N >> (idx + 1);
      for (int i = 0; i < N; i++)
        if ((i & span) == 0) begin
          y[i]        = x[i] + x[i+span];
          y[i+span]   = x[i] - x[i+span];
        end
    end
    return y;
  endfunction

  function automatic logic [W-1:0] sh(input logic [W-1:0] x);
    return W'($signed(x) >>> SH);
  endfunction

  // Stage responder: captures on issue, raises result val two cycles later, holds until taken.
  assign stage_recv_val = p2 | stray;
  always @(posedge clk) begin
    if (reset) begin
      p1 <= 0;
      p2 <= 0;
    end else begin
      if (stage_send_val && stage_send_rdy) begin
        p1 <= 1;
        stage_recv_real <= stage_fn(mode, int'(stage_idx), stage_send_real);
        stage_recv_imag <= stage_fn(mode, int'(stage_idx), stage_send_imag);
        idx_log.push_back(int'(stage_idx));
      end else p1 <= 0;
      if (p1) p2 <= 1;
      else if (stage_recv_val && stage_recv_rdy) p2 <= 0;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_send(output int lat);
    lat = 1;
    while (!send_val && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!send_val) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_vec(input int v);
    int lat;
    logic [11:0] seq;
    idx_log.delete();
    mode = tbl[v].mode;
    recv_msg_real = tbl[v].in_re;
    recv_msg_imag = tbl[v].in_im;
    recv_val = 1;
    @(posedge clk); #1;
    recv_val = 0;
    wait_send(lat);
    chk($sformatf("v%0d_latency", v), lat, 10);
    chk($sformatf("v%0d_real", v), send_msg_real, tbl[v].exp_re);
    chk($sformatf("v%0d_imag", v), send_msg_imag, tbl[v].exp_im);
    seq = (idx_log.size() == 3) ? 12'({idx_log[0][3:0], idx_log[1][3:0], idx_log[2][3:0]}) : 12'hfff;
    chk($sformatf("v%0d_stage_seq", v), seq, 12'h012);
    @(posedge clk); #1;
    chk($sformatf("v%0d_idle_after_send", v), {busy, recv_rdy, send_val}, 3'b010);
    chk($sformatf("v%0d_bank_kept", v), send_msg_real, tbl[v].exp_re);
  endtask

  initial begin
    int lat, guard;
    frame_t hold;
    for (int k = 0; k < N; k++) begin
      tbl[0].in_re[k] = W'(k) * 32'h0001_0000;  tbl[0].in_im[k] = '0;
      tbl[0].exp_re[k] = sh(W'(k) * 32'h0001_0000); tbl[0].exp_im[k] = '0;
      tbl[1].in_re[k] = (k == 0) ? 32'hFFFF_0000 : 32'h0003_0000;
      tbl[1].in_im[k] = W'(k) * 32'h0000_8000;
      tbl[1].exp_re[k] = sh(tbl[1].in_re[k]);   tbl[1].exp_im[k] = sh(tbl[1].in_im[k]);
      tbl[2].in_re[k] = (k == 0) ? 32'h0001_0000 : 32'h0;  tbl[2].in_im[k] = '0;
      tbl[2].exp_re[k] = sh(32'h0001_0000);     tbl[2].exp_im[k] = '0;
      tbl[3].in_re[k] = 32'h0001_0000;          tbl[3].in_im[k] = 32'hFFFF_0000;
      tbl[3].exp_re[k] = (k == 0) ? sh(32'h0008_0000) : 32'h0;
      tbl[3].exp_im[k] = (k == 0) ? sh(32'hFFF8_0000) : 32'h0;
    end
    tbl[0].mode = 0; tbl[1].mode = 0; tbl[2].mode = 1; tbl[3].mode = 1;

    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("reset_hs", {recv_rdy, busy, send_val, stage_send_val, stage_recv_rdy}, 5'b10000);
    chk("reset_idx", stage_idx, 2'd0);
    chk("reset_bank", send_msg_real, '0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Operand backpressure in ISSUE, then result backpressure in DONE.
    mode = 0; idx_log.delete();
    stage_send_rdy = 0;
    recv_msg_real = tbl[0].in_re; recv_msg_imag = tbl[0].in_im; recv_val = 1;
    @(posedge clk); #1 recv_val = 0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_issue_c%0d", c), {stage_send_val, stage_recv_rdy, stage_idx}, 4'b1000);
      chk($sformatf("bp_issue_op_c%0d", c), stage_send_real, tbl[0].in_re);
      @(posedge clk); #1;
    end
    stage_send_rdy = 1;
    send_rdy = 0;
    wait_send(lat);
    hold = send_msg_real;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_done_c%0d", c), {send_val, recv_rdy, send_msg_real}, {2'b10, tbl[0].exp_re});
    end
    chk("bp_done_stable", send_msg_real, hold);
    send_rdy = 1;
    @(posedge clk); #1;
    chk("bp_done_release", {busy, recv_rdy}, 2'b01);

    // Reset while waiting on stage 1, then a stray result pulse in IDLE.
    recv_msg_real = tbl[1].in_re; recv_msg_imag = tbl[1].in_im; recv_val = 1;
    @(posedge clk); #1 recv_val = 0;
    guard = 0;
    while (!(stage_recv_rdy && stage_idx == 2'd1) && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("rst_reach_wait1", {stage_recv_rdy, stage_idx}, 3'b101);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("rst_mid_hs", {busy, recv_rdy, stage_send_val, stage_recv_rdy, send_val}, 5'b01000);
    chk("rst_mid_bank", {send_msg_real, stage_idx}, '0);
    stray = 1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stray_c%0d", c), {busy, recv_rdy, stage_recv_rdy, send_msg_imag}, {3'b010, frame_t'(0)});
    end
    stray = 0;
    run_vec(2);

    // Back-to-back frames with recv_val held high.
    mode = 0; idx_log.delete();
    recv_msg_real = tbl[0].in_re; recv_msg_imag = tbl[0].in_im; recv_val = 1;
    @(posedge clk); #1;
    recv_msg_real = tbl[1].in_re; recv_msg_imag = tbl[1].in_im;
    wait_send(lat);
    chk("b2b_a_real", send_msg_real, tbl[0].exp_re);
    chk("b2b_a_imag", send_msg_imag, tbl[0].exp_im);
    @(posedge clk); #1;
    chk("b2b_idle_gap", {recv_rdy, busy}, 2'b10);
    @(posedge clk); #1;
    chk("b2b_second_fire", {busy, stage_send_val, recv_rdy}, 3'b110);
    recv_val = 0;
    wait_send(lat);
    chk("b2b_b_latency", lat, 10);
    chk("b2b_b_real", send_msg_real, tbl[1].exp_re);
    chk("b2b_b_imag", send_msg_imag, tbl[1].exp_im);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Iterative FFT controller: accepts one frame of N_SAMPLES complex samples and holds it in an internal register bank.
- Drives a single runtime-configurable FFT stage datapath (butterflies, crossbars, twiddles) LOG2N times, once per stage 0..LOG2N-1, writing each result back into the bank.
- Presents the finished frame downstream.
- Trades throughput for area versus a fully unrolled cascade of stages.

Parameters:
- BIT_WIDTH, 32, sample word width (two's-complement fixed point)
- DECIMAL_PT, 16, fractional bits; passed through for scaling rules only
- N_SAMPLES, 8, frame size; power of two, >= 4
- LOG2N, $clog2(N_SAMPLES), number of stages; derived, not overridden

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- recv_msg_real  in  [N_SAMPLES-1:0][BIT_WIDTH]  input frame, real parts
- recv_msg_imag  in  [N_SAMPLES-1:0][BIT_WIDTH]  input frame, imaginary parts
- recv_val  in  1  input frame valid
- recv_rdy  out  1  sequencer can accept a frame
- send_msg_real  out  [N_SAMPLES-1:0][BIT_WIDTH]  result frame, real parts
- send_msg_imag  out  [N_SAMPLES-1:0][BIT_WIDTH]  result frame, imaginary parts
- send_val  out  1  result frame valid
- send_rdy  in  1  downstream accepts result
- stage_send_real  out  [N_SAMPLES-1:0][BIT_WIDTH]  operand frame to stage datapath
- stage_send_imag  out  [N_SAMPLES-1:0][BIT_WIDTH]  operand frame, imaginary parts
- stage_send_val  out  1  operand valid
- stage_send_rdy  in  1  stage datapath accepts operand
- stage_idx  out  $clog2(LOG2N) (min 1)  current stage number for datapath configuration
- stage_recv_real  in  [N_SAMPLES-1:0][BIT_WIDTH]  stage result frame, real parts
- stage_recv_imag  in  [N_SAMPLES-1:0][BIT_WIDTH]  stage result frame, imaginary parts
- stage_recv_val  in  1  stage result valid
- stage_recv_rdy  out  1  sequencer accepts stage result
- busy  out  1  high in any state except IDLE

Behaviour:
- Handshake convention: a transfer occurs on a rising edge where val && rdy. Val must not depend combinationally on rdy of the same interface.
- States: IDLE, ISSUE, WAIT, DONE; 2-bit state register.
- IDLE:
  - recv_rdy=1.
  - On recv fire: latch the frame into the bank, stage counter <= 0, go to ISSUE.
- ISSUE:
  - stage_send_val=1; stage_send_* = bank; stage_idx = stage counter.
  - On stage_send fire, go to WAIT.
- WAIT:
  - stage_recv_rdy=1.
  - On stage_recv fire: bank <= stage_recv_* (scaled if the optional feature is enabled).
  - If counter == LOG2N-1, go to DONE; else counter += 1 and go to ISSUE.
- DONE:
  - send_val=1; send_msg_* = bank.
  - On send fire, go to IDLE.
- Outside their owning state, recv_rdy, stage_send_val, stage_recv_rdy and send_val are all 0.
- A stage_recv_val arriving outside WAIT is ignored (not consumed).
- stage_idx holds its value through WAIT and is 0 in IDLE.
- Bank registers are only written on recv fire or stage_recv fire. The bank is not cleared on send.
- Latency, recv fire to send_val: LOG2N*(1+Ls) + LOG2N + 1 cycles.
  - Ls is the datapath latency from stage_send fire to stage_recv_val, with all rdys high.
  - Each stage costs 1 ISSUE cycle, then Ls cycles in WAIT, then 1 cycle for the WAIT→ISSUE/DONE transition.
- Back-to-back frames: the next recv fire is possible in the cycle after the send fire. There is no overlap.
- Backpressure: ISSUE and DONE hold indefinitely while the relevant rdy is low. Outputs stay stable.
- Reset, including mid-frame:
  - Next cycle: state=IDLE, counter=0.
  - All val/rdy outputs take IDLE values: recv_rdy=1, others 0; busy=0.
  - Bank cleared to 0. In-flight data is dropped.
  - A stage result that arrives later is not accepted until a new frame reaches WAIT.
- N_SAMPLES=4: LOG2N=2, stage_idx width 1.

Optional Feature:
- Macro: FFT_SEQ_STAGE_SCALE_EN
- Defined: each stage result word is arithmetic-shifted right by 1 (sign preserved, truncation toward -inf) before the bank write. The final output is scaled by 1/N, which prevents overflow.
- Undefined: results are written unmodified. Overflow is the datapath's responsibility.

Test Plan:
- Configuration: N_SAMPLES=8, BIT_WIDTH=32, DECIMAL_PT=16. Stage stub is identity with Ls=1 (echoes operand, records stage_idx).
  - Frame of real k*0x00010000, imag 0 → stage_idx sequence 0,1,2; send frame equals input; send_val asserted exactly 10 cycles after recv fire.
  - Same run with FFT_SEQ_STAGE_SCALE_EN defined → output real k*0x00002000; input word 0xFFFF0000 (-1.0) → 0xFFFFE000.
- Configuration: real stage datapath, scaling off.
  - Impulse x[0]=0x00010000, rest 0 → all 8 outputs real 0x00010000, imag 0.
- Backpressure:
  - Hold stage_send_rdy low 5 cycles in ISSUE → operands and stage_idx stable; no WAIT entry.
  - Hold send_rdy low 4 cycles in DONE → send_msg stable; recv_rdy stays 0.
- Reset mid-operation:
  - Assert reset during WAIT of stage 1 → next cycle busy=0, recv_rdy=1, stage_send_val=0.
  - A stray stage_recv_val pulse is not consumed; a new frame then completes correctly.
- Back-to-back frames:
  - Two frames with recv_val held high → second recv fire in the cycle after the first send fire.
  - Both outputs correct and in order.
